// File: rtl/psr_pkg.sv
// Shared PSR definitions: mode encodings, PSR bit positions, the packed
// SPSR stack entry and helpers for building/updating PSR values.
package psr_pkg;

    typedef enum logic [4:0] {
        MODE_USR = 5'b10000,
        MODE_FIQ = 5'b10001,
        MODE_IRQ = 5'b10010,
        MODE_SVC = 5'b10011,
        MODE_ABT = 5'b10111,
        MODE_UND = 5'b11011,
        MODE_SYS = 5'b11111
    } mode_e;

    localparam int unsigned PSR_NZCV_HI = 31;
    localparam int unsigned PSR_NZCV_LO = 28;
    localparam int unsigned PSR_I       = 7;
    localparam int unsigned PSR_F       = 6;
    localparam int unsigned PSR_T       = 5;
    localparam int unsigned PSR_MODE_HI = 4;
    localparam int unsigned PSR_MODE_LO = 0;

    typedef struct packed {
        logic [3:0] nzcv;
        logic       i;
        logic       f;
        logic [4:0] mode;
    } psr_entry_t;

    localparam psr_entry_t PSR_RESET = '{nzcv: 4'h0, i: 1'b1, f: 1'b1, mode: MODE_SVC};

    function automatic logic mode_valid(logic [4:0] m);
        case (m)
            MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
            MODE_ABT, MODE_UND, MODE_SYS: mode_valid = 1'b1;
            default:                      mode_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] psr_word(psr_entry_t e);
        logic [31:0] w;
        w                            = '0;
        w[PSR_NZCV_HI:PSR_NZCV_LO]   = e.nzcv;
        w[PSR_I]                     = e.i;
        w[PSR_F]                     = e.f;
        w[PSR_T]                     = 1'b0;
        w[PSR_MODE_HI:PSR_MODE_LO]   = e.mode;
        return w;
    endfunction

    // Control-field update; a bad mode encoding keeps the old mode but I/F still land.
    function automatic psr_entry_t psr_ctrl_write(psr_entry_t cur, logic we, logic i,
                                                  logic f, logic [4:0] mode);
        psr_entry_t r;
        r = cur;
        if (we) begin
            r.i = i;
            r.f = f;
            if (mode_valid(mode)) r.mode = mode;
        end
        return r;
    endfunction

endpackage

// File: rtl/psr_bank_if.sv
// Core-side bundle for psr_bank: exception strobes, ALU flags, MSR/MRS and status outputs.
interface psr_bank_if #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned DW    = $clog2(DEPTH + 1)
);
    logic          en;
    logic          i_exc_enter;
    logic [4:0]    i_exc_mode;
    logic          i_exc_fiq;
    logic          i_exc_return;
    logic          i_nzcv_flag;
    logic [3:0]    i_nzcv_alu;
    logic          i_xpsr_en_ex;
    logic          i_xpsr_sel;
    logic [1:0]    i_xpsr_fmask;
    logic [31:0]   i_xpsr_reg;
    logic [31:0]   o_xpsr_reg;
    logic [3:0]    o_nzcv;
    logic [3:0]    o_nzcv_next;
    logic [4:0]    o_mode;
    logic          o_priv;
    logic          o_irq_mask;
    logic          o_fiq_mask;
    logic [DW-1:0] o_depth;
    logic          o_full;
    logic          o_empty;
    logic          o_ovf;
    logic          o_unf;

    modport master (
        output en, i_exc_enter, i_exc_mode, i_exc_fiq, i_exc_return, i_nzcv_flag,
               i_nzcv_alu, i_xpsr_en_ex, i_xpsr_sel, i_xpsr_fmask, i_xpsr_reg,
        input  o_xpsr_reg, o_nzcv, o_nzcv_next, o_mode, o_priv, o_irq_mask,
               o_fiq_mask, o_depth, o_full, o_empty, o_ovf, o_unf
    );

    modport slave (
        input  en, i_exc_enter, i_exc_mode, i_exc_fiq, i_exc_return, i_nzcv_flag,
               i_nzcv_alu, i_xpsr_en_ex, i_xpsr_sel, i_xpsr_fmask, i_xpsr_reg,
        output o_xpsr_reg, o_nzcv, o_nzcv_next, o_mode, o_priv, o_irq_mask,
               o_fiq_mask, o_depth, o_full, o_empty, o_ovf, o_unf
    );
endinterface

// File: rtl/psr_stack.sv
// DEPTH-entry LIFO of saved PSRs with push, pop and in-place top rewrite.
module psr_stack import psr_pkg::*; #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          top_we,
    input  psr_entry_t    push_data,
    input  psr_entry_t    top_wdata,
    output psr_entry_t    top_rdata,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);
    psr_entry_t    mem_q [DEPTH];
    psr_entry_t    mem_d [DEPTH];
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;
    logic [DW-1:0] top_idx;

    assign empty   = (depth_q == '0);
    assign full    = (depth_q == DW'(DEPTH));
    assign depth   = depth_q;
    assign top_idx = depth_q - DW'(1);

    // Entries are addressed by compare rather than index so the counter width
    // never has to match the array's address width.
    always_comb begin
        mem_d     = mem_q;
        depth_d   = depth_q;
        top_rdata = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!empty && DW'(i) == top_idx) begin
                top_rdata = mem_q[i];
                if (top_we) mem_d[i] = top_wdata;
            end
            if (push && !full && DW'(i) == depth_q) mem_d[i] = push_data;
        end
        if (push && !full)       depth_d = depth_q + DW'(1);
        else if (pop && !empty)  depth_d = depth_q - DW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            depth_q <= depth_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: rtl/psr_bank.sv
// CPSR register with nested-exception SPSR stack; serves MRS/MSR and feeds
// condition evaluation and interrupt masking.
module psr_bank import psr_pkg::*; #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned DW    = $clog2(DEPTH + 1)
) (
    input logic       clk,
    input logic       rst_n,
    psr_bank_if.slave bus
);
    psr_entry_t    cpsr_q;
    psr_entry_t    cpsr_d;
    psr_entry_t    cpsr_wr;
    psr_entry_t    spsr_wr;
    psr_entry_t    top_entry;
    logic [3:0]    nzcv_next;
    logic          priv;
    logic          cpsr_we;
    logic          spsr_we;
    logic          push;
    logic          pop;
    logic          top_we;
    logic          ovf_q;
    logic          ovf_d;
    logic          unf_q;
    logic          unf_d;
    logic          full;
    logic          empty;
    logic [DW-1:0] depth;
    logic          xpsr_unused;

    assign priv        = (cpsr_q.mode != MODE_USR);
    assign cpsr_we     = bus.i_xpsr_en_ex & ~bus.i_xpsr_sel;
    assign spsr_we     = bus.i_xpsr_en_ex & bus.i_xpsr_sel;
    assign xpsr_unused = ^{bus.i_xpsr_reg[27:8], bus.i_xpsr_reg[PSR_T]};

    // CPSR/SPSR values as they would be after this cycle's MSR and ALU update.
    always_comb begin
        nzcv_next = cpsr_q.nzcv;
        if (cpsr_we && bus.i_xpsr_fmask[1]) nzcv_next = bus.i_xpsr_reg[PSR_NZCV_HI:PSR_NZCV_LO];
        else if (bus.i_nzcv_flag)           nzcv_next = bus.i_nzcv_alu;

        cpsr_wr = psr_ctrl_write(cpsr_q, cpsr_we & bus.i_xpsr_fmask[0] & priv,
                                 bus.i_xpsr_reg[PSR_I], bus.i_xpsr_reg[PSR_F],
                                 bus.i_xpsr_reg[PSR_MODE_HI:PSR_MODE_LO]);
        cpsr_wr.nzcv = nzcv_next;

        spsr_wr = psr_ctrl_write(top_entry, bus.i_xpsr_fmask[0],
                                 bus.i_xpsr_reg[PSR_I], bus.i_xpsr_reg[PSR_F],
                                 bus.i_xpsr_reg[PSR_MODE_HI:PSR_MODE_LO]);
        if (bus.i_xpsr_fmask[1]) spsr_wr.nzcv = bus.i_xpsr_reg[PSR_NZCV_HI:PSR_NZCV_LO];
    end

    always_comb begin
        cpsr_d = cpsr_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        push   = 1'b0;
        pop    = 1'b0;
        top_we = 1'b0;
        if (bus.en) begin
            if (bus.i_exc_enter && bus.i_exc_return && !empty) begin
                // Tail-chain: the saved context stays put, only the handler changes.
                cpsr_d.nzcv = top_entry.nzcv;
                cpsr_d.mode = bus.i_exc_mode;
                cpsr_d.i    = 1'b1;
                cpsr_d.f    = top_entry.f | bus.i_exc_fiq;
            end else if (bus.i_exc_enter) begin
                push        = ~full;
                ovf_d       = ovf_q | full;
                unf_d       = unf_q | bus.i_exc_return;
                cpsr_d.nzcv = nzcv_next;
                cpsr_d.mode = bus.i_exc_mode;
                cpsr_d.i    = 1'b1;
                cpsr_d.f    = cpsr_wr.f | bus.i_exc_fiq;
            end else if (bus.i_exc_return) begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    cpsr_d = top_entry;
                    pop    = 1'b1;
                end
            end else begin
                cpsr_d = cpsr_wr;
                top_we = spsr_we & ~empty;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpsr_q <= PSR_RESET;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            cpsr_q <= cpsr_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    psr_stack #(.DEPTH(DEPTH)) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .top_we    (top_we),
        .push_data (cpsr_wr),
        .top_wdata (spsr_wr),
        .top_rdata (top_entry),
        .depth     (depth),
        .full      (full),
        .empty     (empty)
    );

    assign bus.o_xpsr_reg  = (bus.i_xpsr_sel && !empty) ? psr_word(top_entry) : psr_word(cpsr_q);
    assign bus.o_nzcv      = cpsr_q.nzcv;
    assign bus.o_nzcv_next = nzcv_next;
    assign bus.o_mode      = cpsr_q.mode;
    assign bus.o_priv      = priv;
    assign bus.o_irq_mask  = cpsr_q.i;
    assign bus.o_fiq_mask  = cpsr_q.f;
    assign bus.o_depth     = depth;
    assign bus.o_full      = full;
    assign bus.o_empty     = empty;
    assign bus.o_ovf       = ovf_q;
    assign bus.o_unf       = unf_q;
endmodule

// File: tb/tb_psr_bank.sv
// Bench for psr_bank: DEPTH=4 and DEPTH=2 instances share stimulus and are
// compared every cycle against an array-based model of the PSR rules.
module tb_psr_bank;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    psr_bank_if #(.DEPTH(4)) bus4 ();
    psr_bank_if #(.DEPTH(2)) bus2 ();

    psr_bank #(.DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    psr_bank #(.DEPTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus2.en           = bus4.en;
    assign bus2.i_exc_enter  = bus4.i_exc_enter;
    assign bus2.i_exc_mode   = bus4.i_exc_mode;
    assign bus2.i_exc_fiq    = bus4.i_exc_fiq;
    assign bus2.i_exc_return = bus4.i_exc_return;
    assign bus2.i_nzcv_flag  = bus4.i_nzcv_flag;
    assign bus2.i_nzcv_alu   = bus4.i_nzcv_alu;
    assign bus2.i_xpsr_en_ex = bus4.i_xpsr_en_ex;
    assign bus2.i_xpsr_sel   = bus4.i_xpsr_sel;
    assign bus2.i_xpsr_fmask = bus4.i_xpsr_fmask;
    assign bus2.i_xpsr_reg   = bus4.i_xpsr_reg;

    int checks   = 0;
    int failures = 0;

    // Model state per instance: k = 0 is DEPTH 4, k = 1 is DEPTH 2.
    logic [3:0]  m_nzcv [2];
    logic        m_i    [2];
    logic        m_f    [2];
    logic [4:0]  m_mode [2];
    logic [10:0] m_stk  [2][4];
    int          m_dep  [2];
    logic        m_ovf  [2];
    logic        m_unf  [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int cap(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic logic valid_mode(input logic [4:0] m);
        return m inside {5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};
    endfunction

    function automatic logic [31:0] word(input logic [3:0] n, input logic i, input logic f,
                                         input logic [4:0] m);
        return {n, 20'b0, i, f, 1'b0, m};
    endfunction

    function automatic logic [3:0] exp_nzcv_next(input int k);
        if (bus4.i_xpsr_en_ex && !bus4.i_xpsr_sel && bus4.i_xpsr_fmask[1])
            return bus4.i_xpsr_reg[31:28];
        if (bus4.i_nzcv_flag) return bus4.i_nzcv_alu;
        return m_nzcv[k];
    endfunction

    function automatic logic [31:0] exp_xpsr(input int k);
        logic [10:0] e;
        if (bus4.i_xpsr_sel && m_dep[k] > 0) begin
            e = m_stk[k][m_dep[k] - 1];
            return word(e[10:7], e[6], e[5], e[4:0]);
        end
        return word(m_nzcv[k], m_i[k], m_f[k], m_mode[k]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_nzcv[k] = 4'h0; m_i[k] = 1'b1; m_f[k] = 1'b1; m_mode[k] = 5'h13;
            m_dep[k] = 0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
            for (int j = 0; j < 4; j++) m_stk[k][j] = '0;
        end
    endtask

    task automatic model_step(input int k);
        logic [3:0]  nn;
        logic        wi, wf;
        logic [4:0]  wm;
        logic [10:0] top, e;
        logic        ent, ret, empty, full;
        logic [31:0] d;
        if (!bus4.en) return;
        d   = bus4.i_xpsr_reg;
        ent = bus4.i_exc_enter;
        ret = bus4.i_exc_return;
        nn  = exp_nzcv_next(k);
        wi  = m_i[k]; wf = m_f[k]; wm = m_mode[k];
        if (bus4.i_xpsr_en_ex && !bus4.i_xpsr_sel && bus4.i_xpsr_fmask[0] && m_mode[k] != 5'h10) begin
            wi = d[7]; wf = d[6];
            if (valid_mode(d[4:0])) wm = d[4:0];
        end
        empty = (m_dep[k] == 0);
        full  = (m_dep[k] == cap(k));
        top   = empty ? 11'h0 : m_stk[k][m_dep[k] - 1];
        if (ent && ret && !empty) begin
            m_nzcv[k] = top[10:7]; m_mode[k] = bus4.i_exc_mode;
            m_i[k] = 1'b1; m_f[k] = top[5] | bus4.i_exc_fiq;
        end else if (ent) begin
            if (full) m_ovf[k] = 1'b1;
            else begin
                m_stk[k][m_dep[k]] = {nn, wi, wf, wm};
                m_dep[k]++;
            end
            if (ret) m_unf[k] = 1'b1;
            m_nzcv[k] = nn; m_mode[k] = bus4.i_exc_mode;
            m_i[k] = 1'b1; m_f[k] = wf | bus4.i_exc_fiq;
        end else if (ret) begin
            if (empty) m_unf[k] = 1'b1;
            else begin
                {m_nzcv[k], m_i[k], m_f[k], m_mode[k]} = top;
                m_dep[k]--;
            end
        end else begin
            m_nzcv[k] = nn; m_i[k] = wi; m_f[k] = wf; m_mode[k] = wm;
            if (bus4.i_xpsr_en_ex && bus4.i_xpsr_sel && !empty) begin
                e = top;
                if (bus4.i_xpsr_fmask[1]) e[10:7] = d[31:28];
                if (bus4.i_xpsr_fmask[0]) begin
                    e[6] = d[7]; e[5] = d[6];
                    if (valid_mode(d[4:0])) e[4:0] = d[4:0];
                end
                m_stk[k][m_dep[k] - 1] = e;
            end
        end
    endtask

    task automatic check_dut(input int k, input string nm, input logic [3:0] nz,
                             input logic [3:0] nzn, input logic [4:0] mode, input logic priv,
                             input logic irqm, input logic fiqm, input int dep,
                             input logic full, input logic empty, input logic ovf,
                             input logic unf, input logic [31:0] xpsr);
        check_eq({nm, ".nzcv"},      32'(nz),    32'(m_nzcv[k]));
        check_eq({nm, ".nzcv_next"}, 32'(nzn),   32'(exp_nzcv_next(k)));
        check_eq({nm, ".mode"},      32'(mode),  32'(m_mode[k]));
        check_eq({nm, ".priv"},      32'(priv),  32'(m_mode[k] != 5'h10));
        check_eq({nm, ".irq_mask"},  32'(irqm),  32'(m_i[k]));
        check_eq({nm, ".fiq_mask"},  32'(fiqm),  32'(m_f[k]));
        check_eq({nm, ".depth"},     32'(dep),   32'(m_dep[k]));
        check_eq({nm, ".full"},      32'(full),  32'(m_dep[k] == cap(k)));
        check_eq({nm, ".empty"},     32'(empty), 32'(m_dep[k] == 0));
        check_eq({nm, ".ovf"},       32'(ovf),   32'(m_ovf[k]));
        check_eq({nm, ".unf"},       32'(unf),   32'(m_unf[k]));
        check_eq({nm, ".xpsr"},      xpsr,       exp_xpsr(k));
    endtask

    task automatic tick();
        @(negedge clk);
        check_dut(0, "d4", bus4.o_nzcv, bus4.o_nzcv_next, bus4.o_mode, bus4.o_priv,
                  bus4.o_irq_mask, bus4.o_fiq_mask, 32'(bus4.o_depth), bus4.o_full,
                  bus4.o_empty, bus4.o_ovf, bus4.o_unf, bus4.o_xpsr_reg);
        check_dut(1, "d2", bus2.o_nzcv, bus2.o_nzcv_next, bus2.o_mode, bus2.o_priv,
                  bus2.o_irq_mask, bus2.o_fiq_mask, 32'(bus2.o_depth), bus2.o_full,
                  bus2.o_empty, bus2.o_ovf, bus2.o_unf, bus2.o_xpsr_reg);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic idle();
        bus4.en = 1'b1; bus4.i_exc_enter = 1'b0; bus4.i_exc_mode = 5'h13; bus4.i_exc_fiq = 1'b0;
        bus4.i_exc_return = 1'b0; bus4.i_nzcv_flag = 1'b0; bus4.i_nzcv_alu = 4'h0;
        bus4.i_xpsr_en_ex = 1'b0; bus4.i_xpsr_sel = 1'b0; bus4.i_xpsr_fmask = 2'b00;
        bus4.i_xpsr_reg = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        #2;
        model_reset();
        check_eq("rst.xpsr",  bus4.o_xpsr_reg,       32'h0000_00D3);
        check_eq("rst.depth", 32'(bus4.o_depth),     32'd0);
        check_eq("rst.empty", 32'(bus4.o_empty),     32'd1);
        check_eq("rst.ovf2",  32'(bus2.o_ovf),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic enter_only(input logic [4:0] m, input logic fiq);
        idle(); bus4.i_exc_enter = 1'b1; bus4.i_exc_mode = m; bus4.i_exc_fiq = fiq; tick();
    endtask

    task automatic ret_only();
        idle(); bus4.i_exc_return = 1'b1; tick();
    endtask

    task automatic msr_cpsr(input logic [1:0] fm, input logic [31:0] d);
        idle(); bus4.i_xpsr_en_ex = 1'b1; bus4.i_xpsr_fmask = fm; bus4.i_xpsr_reg = d; tick();
    endtask

    function automatic logic [4:0] pick_mode();
        case ($urandom_range(0, 7))
            0: return 5'h10;
            1: return 5'h11;
            2: return 5'h12;
            3: return 5'h13;
            4: return 5'h17;
            5: return 5'h1B;
            6: return 5'h1F;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] d;
        rst_n = 1'b1;
        idle();
        #1;
        do_reset();

        // nested IRQ then FIQ, unwound by two returns
        msr_cpsr(2'b10, 32'hA000_0000);
        enter_only(5'h12, 1'b0);
        enter_only(5'h11, 1'b1);
        idle();
        check_eq("nest.mode",  32'(bus4.o_mode),     32'h11);
        check_eq("nest.imask", 32'(bus4.o_irq_mask), 32'd1);
        check_eq("nest.fmask", 32'(bus4.o_fiq_mask), 32'd1);
        check_eq("nest.depth", 32'(bus4.o_depth),    32'd2);
        ret_only();
        ret_only();
        check_eq("unnest.mode",  32'(bus4.o_mode),  32'h13);
        check_eq("unnest.nzcv",  32'(bus4.o_nzcv),  32'hA);
        check_eq("unnest.depth", 32'(bus4.o_depth), 32'd0);

        // overflow on the two-deep instance
        do_reset();
        enter_only(5'h12, 1'b0);
        enter_only(5'h17, 1'b0);
        enter_only(5'h1B, 1'b0);
        check_eq("ovf.depth", 32'(bus2.o_depth), 32'd2);
        check_eq("ovf.flag",  32'(bus2.o_ovf),   32'd1);
        check_eq("ovf.mode",  32'(bus2.o_mode),  32'h1B);
        ret_only();
        ret_only();
        check_eq("ovf.restore", bus2.o_xpsr_reg,     32'h0000_00D3);
        check_eq("ovf.d4depth", 32'(bus4.o_depth),   32'd1);

        // ALU flags in the entry cycle reach both CPSR and the saved SPSR
        do_reset();
        idle(); bus4.i_exc_enter = 1'b1; bus4.i_exc_mode = 5'h12;
        bus4.i_nzcv_flag = 1'b1; bus4.i_nzcv_alu = 4'b0110;
        tick();
        idle(); bus4.i_xpsr_sel = 1'b1;
        #1;
        check_eq("flags.cpsr", 32'(bus4.o_nzcv), 32'h6);
        check_eq("flags.spsr", bus4.o_xpsr_reg,  32'h6000_00D3);
        tick();

        // user mode may write flags but not the control field
        do_reset();
        msr_cpsr(2'b01, 32'h0000_0010);
        msr_cpsr(2'b11, 32'hF000_0013);
        check_eq("usr.nzcv", 32'(bus4.o_nzcv), 32'hF);
        check_eq("usr.mode", 32'(bus4.o_mode), 32'h10);
        check_eq("usr.priv", 32'(bus4.o_priv), 32'd0);

        // tail-chain at depth 1, then underflow from empty
        do_reset();
        msr_cpsr(2'b10, 32'h5000_0000);
        enter_only(5'h12, 1'b0);
        idle(); bus4.i_nzcv_flag = 1'b1; bus4.i_nzcv_alu = 4'h3; tick();
        idle(); bus4.i_exc_enter = 1'b1; bus4.i_exc_return = 1'b1; bus4.i_exc_mode = 5'h17; tick();
        check_eq("tail.depth", 32'(bus4.o_depth), 32'd1);
        check_eq("tail.mode",  32'(bus4.o_mode),  32'h17);
        check_eq("tail.nzcv",  32'(bus4.o_nzcv),  32'h5);
        ret_only();
        ret_only();
        check_eq("unf.flag", 32'(bus4.o_unf),   32'd1);
        check_eq("unf.cpsr", bus4.o_xpsr_reg,   32'h5000_00D3);

        // randomized traffic with periodic mid-run resets
        for (int c = 0; c < 1600; c++) begin
            if (c % 400 == 399) begin
                do_reset();
                continue;
            end
            bus4.en           = ($urandom_range(0, 9) != 0);
            bus4.i_exc_enter  = ($urandom_range(0, 99) < 18);
            bus4.i_exc_return = ($urandom_range(0, 99) < 15);
            bus4.i_exc_mode   = pick_mode();
            bus4.i_exc_fiq    = ($urandom_range(0, 3) == 0);
            bus4.i_nzcv_flag  = ($urandom_range(0, 2) == 0);
            bus4.i_nzcv_alu   = 4'($urandom);
            bus4.i_xpsr_en_ex = ($urandom_range(0, 4) == 0);
            bus4.i_xpsr_sel   = ($urandom_range(0, 1) == 1);
            bus4.i_xpsr_fmask = 2'($urandom);
            d = $urandom;
            d[4:0] = pick_mode();
            bus4.i_xpsr_reg = d;
            if (bus4.i_xpsr_sel && (bus4.i_exc_enter || bus4.i_exc_return)) bus4.i_xpsr_en_ex = 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
